// File: rtl/multi_blinky.sv
// multi_blinky: NumLeds-channel LED pattern generator.
// Each channel runs in OFF / ON / BLINK / DIM_BLINK mode. Its mode, half
// period and PWM duty are written at runtime through a valid/ready config
// port. A single free-running PWM counter is shared by all channels.
// led_o is active-high; the board top inverts it for active-low pins.
//
// Optional build macro: MULTI_BLINKY_PHASE_SYNC_EN
//   When defined, the block gains input sync_i. A high sync_i reloads every
//   channel counter and clears every phase, which phase-aligns the channels.
//   A config write on the same edge still wins for its target channel.
//   When undefined, sync_i and its logic are absent.

module multi_blinky #(
  parameter int  NumLeds           = 4,
  parameter int  CounterWidth      = 24,
  parameter int  DefaultHalfPeriod = 5000000,
  parameter int  PwmWidth          = 8,
  localparam int ChanWidth         = (NumLeds > 1) ? $clog2(NumLeds) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
`ifdef MULTI_BLINKY_PHASE_SYNC_EN
  input  logic                    sync_i,
`endif
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [ChanWidth-1:0]    cfg_chan_i,
  input  logic [1:0]              cfg_mode_i,
  input  logic [CounterWidth-1:0] cfg_half_period_i,
  input  logic [PwmWidth-1:0]     cfg_duty_i,
  output logic [NumLeds-1:0]      led_o,
  output logic [NumLeds-1:0]      wrap_o
);

  // Channel operating modes.
  localparam logic [1:0] ModeOff      = 2'd0;
  localparam logic [1:0] ModeOn       = 2'd1;
  localparam logic [1:0] ModeBlink    = 2'd2;
  localparam logic [1:0] ModeDimBlink = 2'd3;

  // Reset-time channel configuration.
  localparam logic [CounterWidth-1:0] DefHalf   = CounterWidth'(DefaultHalfPeriod);
  localparam logic [CounterWidth-1:0] DefReload = CounterWidth'(DefaultHalfPeriod - 1);
  localparam logic [PwmWidth-1:0]     DutyFull  = {PwmWidth{1'b1}};

  // Counter reload value: a half period of 0 behaves like 1, so the
  // channel toggles every cycle instead of counting through 2^N cycles.
  function automatic logic [CounterWidth-1:0] reload_of(
    input logic [CounterWidth-1:0] half
  );
    logic [CounterWidth-1:0] r;
    if (half == {CounterWidth{1'b0}}) begin
      r = {CounterWidth{1'b0}};
    end else begin
      r = half - CounterWidth'(1);
    end
    return r;
  endfunction

  // Only the two blinking modes advance the half-period counter.
  function automatic logic is_counting(input logic [1:0] mode);
    return (mode == ModeBlink) || (mode == ModeDimBlink);
  endfunction

  // ---------------------------------------------------------------------
  // Shared state: config handshake and PWM counter
  // ---------------------------------------------------------------------
  logic                ready_q;
  logic                ready_d;
  logic [PwmWidth-1:0] pwm_q;
  logic [PwmWidth-1:0] pwm_d;
  logic                cfg_fire;
  logic                sync_s;

  // A write is taken only once ready is registered high, so nothing issued
  // while reset is held (or on the release edge) can land.
  assign cfg_fire    = cfg_valid_i & ready_q;
  assign cfg_ready_o = ready_q;

`ifdef MULTI_BLINKY_PHASE_SYNC_EN
  assign sync_s = sync_i;
`else
  assign sync_s = 1'b0;
`endif

  // Next-state for the shared handshake flag and free-running PWM counter.
  always_comb begin
    ready_d = 1'b1;
    pwm_d   = pwm_q + PwmWidth'(1);
  end

  // Shared registers; PWM counter wraps naturally at 2^PwmWidth.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_q <= 1'b0;
      pwm_q   <= {PwmWidth{1'b0}};
    end else begin
      ready_q <= ready_d;
      pwm_q   <= pwm_d;
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel configuration, counter, phase and output decode
  // ---------------------------------------------------------------------
  for (genvar c = 0; c < NumLeds; c++) begin : g_chan
    logic [1:0]              mode_q;
    logic [1:0]              mode_d;
    logic [CounterWidth-1:0] half_q;
    logic [CounterWidth-1:0] half_d;
    logic [PwmWidth-1:0]     duty_q;
    logic [PwmWidth-1:0]     duty_d;
    logic [CounterWidth-1:0] cnt_q;
    logic [CounterWidth-1:0] cnt_d;
    logic                    phase_q;
    logic                    phase_d;
    logic                    wrap_q;
    logic                    wrap_d;
    logic                    wr_s;
    logic                    led_s;

    // Indices at or above NumLeds never match, so such writes are dropped.
    assign wr_s = cfg_fire && (cfg_chan_i == ChanWidth'(c));

    // Channel next-state: a config write beats sync, sync beats counting.
    always_comb begin
      mode_d  = mode_q;
      half_d  = half_q;
      duty_d  = duty_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      wrap_d  = 1'b0;
      if (wr_s) begin
        // Restart cleanly from the new settings, even if the old counter
        // was about to expire on this very edge.
        mode_d  = cfg_mode_i;
        half_d  = cfg_half_period_i;
        duty_d  = cfg_duty_i;
        cnt_d   = reload_of(cfg_half_period_i);
        phase_d = 1'b0;
      end else if (sync_s) begin
        cnt_d   = reload_of(half_q);
        phase_d = 1'b0;
      end else if (is_counting(mode_q)) begin
        if (cnt_q != {CounterWidth{1'b0}}) begin
          cnt_d = cnt_q - CounterWidth'(1);
        end else begin
          cnt_d   = reload_of(half_q);
          phase_d = ~phase_q;
          wrap_d  = 1'b1;
        end
      end else begin
        // Static modes park the counter so a later mode change to a
        // blinking mode starts a full half period.
        cnt_d   = reload_of(half_q);
        phase_d = 1'b0;
      end
    end

    // Channel registers with reset defaults (BLINK at the default rate).
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        mode_q  <= ModeBlink;
        half_q  <= DefHalf;
        duty_q  <= DutyFull;
        cnt_q   <= DefReload;
        phase_q <= 1'b0;
        wrap_q  <= 1'b0;
      end else begin
        mode_q  <= mode_d;
        half_q  <= half_d;
        duty_q  <= duty_d;
        cnt_q   <= cnt_d;
        phase_q <= phase_d;
        wrap_q  <= wrap_d;
      end
    end

    // LED decode from registered state only; cfg inputs never reach it.
    always_comb begin
      led_s = 1'b0;
      case (mode_q)
        ModeOff:      led_s = 1'b0;
        ModeOn:       led_s = 1'b1;
        ModeBlink:    led_s = phase_q;
        ModeDimBlink: led_s = phase_q & (pwm_q < duty_q);
        default:      led_s = 1'b0;
      endcase
    end

    assign led_o[c]  = led_s;
    assign wrap_o[c] = wrap_q;
  end

endmodule

// File: tb/tb_multi_blinky.sv
// Directed self-checking bench for multi_blinky.
// Main instance: NumLeds=4, DefaultHalfPeriod=4, PwmWidth=3.
// Second instance with NumLeds=3 exercises the out-of-range channel write.
// Expected values come from a per-channel description (mode, restart edge,
// half period, duty) updated by hand at each directed step; k counts edges
// since the latest reset release.

module tb_multi_blinky;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic [1:0]  cfg_chan;
  logic [1:0]  cfg_mode;
  logic [23:0] cfg_half;
  logic [2:0]  cfg_duty;
  logic        cfg_ready;
  logic [3:0]  led;
  logic [3:0]  wrap;

  logic        cfg3_valid;
  logic [1:0]  cfg3_chan;
  logic [1:0]  cfg3_mode;
  logic [23:0] cfg3_half;
  logic [2:0]  cfg3_duty;
  logic        cfg3_ready;
  logic [2:0]  led3;
  logic [2:0]  wrap3;

`ifdef MULTI_BLINKY_PHASE_SYNC_EN
  logic        sync;
`endif

  int          compared   = 0;
  int          mismatched = 0;
  int          k;
  int          st [4];
  int          hh [4];
  int          dt [4];
  logic [1:0]  md [4];

  always #5 clk = ~clk;

  multi_blinky #(
    .NumLeds(4), .CounterWidth(24), .DefaultHalfPeriod(4), .PwmWidth(3)
  ) u_dut (
    .clk_i(clk),
    .rst_i(rst),
`ifdef MULTI_BLINKY_PHASE_SYNC_EN
    .sync_i(sync),
`endif
    .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready),
    .cfg_chan_i(cfg_chan),
    .cfg_mode_i(cfg_mode),
    .cfg_half_period_i(cfg_half),
    .cfg_duty_i(cfg_duty),
    .led_o(led),
    .wrap_o(wrap)
  );

  multi_blinky #(
    .NumLeds(3), .CounterWidth(24), .DefaultHalfPeriod(4), .PwmWidth(3)
  ) u_dut3 (
    .clk_i(clk),
    .rst_i(rst),
`ifdef MULTI_BLINKY_PHASE_SYNC_EN
    .sync_i(1'b0),
`endif
    .cfg_valid_i(cfg3_valid),
    .cfg_ready_o(cfg3_ready),
    .cfg_chan_i(cfg3_chan),
    .cfg_mode_i(cfg3_mode),
    .cfg_half_period_i(cfg3_half),
    .cfg_duty_i(cfg3_duty),
    .led_o(led3),
    .wrap_o(wrap3)
  );

  // Phase after t edges from a restart with half period h.
  function automatic logic ph(input int t, input int h);
    return ((t / h) % 2) == 1;
  endfunction

  // Wrap pulse visible after t edges from a restart with half period h.
  function automatic logic wp(input int t, input int h);
    return (t > 0) && ((t % h) == 0);
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic model_defaults();
    for (int c = 0; c < 4; c++) begin
      st[c] = 0;
      hh[c] = 4;
      dt[c] = 7;
      md[c] = 2'd2;
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] el;
    logic [3:0] ew;
    for (int c = 0; c < 4; c++) begin
      int t;
      t = k - st[c];
      case (md[c])
        2'd0: begin el[c] = 1'b0; ew[c] = 1'b0; end
        2'd1: begin el[c] = 1'b1; ew[c] = 1'b0; end
        2'd2: begin el[c] = ph(t, hh[c]); ew[c] = wp(t, hh[c]); end
        default: begin
          el[c] = ph(t, hh[c]) && ((k % 8) < dt[c]);
          ew[c] = wp(t, hh[c]);
        end
      endcase
    end
    chk({tag, ".led"}, led, el);
    chk({tag, ".wrap"}, wrap, ew);
    chk({tag, ".ready"}, {3'b000, cfg_ready}, 4'b0001);
    chk({tag, ".led3"}, {1'b0, led3}, {1'b0, {3{ph(k, 4)}}});
    chk({tag, ".wrap3"}, {1'b0, wrap3}, {1'b0, {3{wp(k, 4)}}});
    chk({tag, ".ready3"}, {3'b000, cfg3_ready}, 4'b0001);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check_all(tag);
    end
  endtask

  task automatic write_cfg(input int c, input logic [1:0] m, input int h, input int d);
    cfg_valid = 1'b1;
    cfg_chan  = 2'(c);
    cfg_mode  = m;
    cfg_half  = 24'(h);
    cfg_duty  = 3'(d);
    tick();
    cfg_valid = 1'b0;
    st[c] = k;
    hh[c] = (h == 0) ? 1 : h;
    md[c] = m;
    dt[c] = d;
    check_all("write");
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".led"}, led, 4'b0000);
    chk({tag, ".wrap"}, wrap, 4'b0000);
    chk({tag, ".ready"}, {3'b000, cfg_ready}, 4'b0000);
    chk({tag, ".led3"}, {1'b0, led3}, 4'b0000);
    chk({tag, ".wrap3"}, {1'b0, wrap3}, 4'b0000);
    chk({tag, ".ready3"}, {3'b000, cfg3_ready}, 4'b0000);
  endtask

  initial begin
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_chan   = 2'd0;
    cfg_mode   = 2'd0;
    cfg_half   = 24'd0;
    cfg_duty   = 3'd0;
    cfg3_valid = 1'b0;
    cfg3_chan  = 2'd0;
    cfg3_mode  = 2'd0;
    cfg3_half  = 24'd0;
    cfg3_duty  = 3'd0;
`ifdef MULTI_BLINKY_PHASE_SYNC_EN
    sync       = 1'b0;
`endif
    k = 0;
    model_defaults();

    // Reset state.
    tick();
    tick();
    check_reset_state("reset");

    // Default blinking: rise after edge 4, fall after 8, rise after 12.
    rst = 1'b0;
    k   = 0;
    run(13, "default");

    // Channel 2 forced ON at edge 14.
    write_cfg(2, 2'd1, 4, 7);
    run(7, "on");

    // Channel 1 DIM_BLINK, half 2, duty 2 at edge 22.
    write_cfg(1, 2'd3, 2, 2);
    run(15, "dim");

    // Channel 3 BLINK with half 0 at edge 38: toggles every cycle.
    write_cfg(3, 2'd2, 0, 7);
    run(13, "half0");

    // Channel 0 rewritten on edge 52, exactly when its counter expires.
    write_cfg(0, 2'd2, 4, 7);

    // Out-of-range channel on the 3-channel instance: no effect.
    cfg3_valid = 1'b1;
    cfg3_chan  = 2'd3;
    cfg3_mode  = 2'd0;
    cfg3_half  = 24'd1;
    cfg3_duty  = 3'd0;
    tick();
    cfg3_valid = 1'b0;
    check_all("oob");
    run(7, "after_oob");

    // Mid-run reset with a pending write that must be dropped.
    rst       = 1'b1;
    cfg_valid = 1'b1;
    cfg_chan  = 2'd2;
    cfg_mode  = 2'd0;
    cfg_half  = 24'd1;
    cfg_duty  = 3'd0;
    tick();
    check_reset_state("midreset");
    rst = 1'b0;
    k   = 0;
    model_defaults();
    tick();
    cfg_valid = 1'b0;
    check_all("release");
    run(11, "restart");

`ifdef MULTI_BLINKY_PHASE_SYNC_EN
    // Sync at edge 13 together with a write to channel 1.
    sync      = 1'b1;
    cfg_valid = 1'b1;
    cfg_chan  = 2'd1;
    cfg_mode  = 2'd2;
    cfg_half  = 24'd2;
    cfg_duty  = 3'd7;
    tick();
    sync      = 1'b0;
    cfg_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      st[c] = k;
    end
    hh[1] = 2;
    check_all("sync");
    run(6, "after_sync");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
